// File: rtl/ca90_seq.sv
// ca90_seq: produces CA90^k(base) on request. The current generation is kept
// between requests so that a request for a later index only has to step
// forward from where the previous one stopped; an earlier index restarts
// from the stored base vector. One CA90 step is applied per clock.
`ifndef DIM
`define DIM 8
`endif

module ca90_seq #(
    parameter int DIM   = `DIM,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [DIM-1:0]   seed,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_idx,
    output logic             req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DIM-1:0]   rsp_vec,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [DIM-1:0]   base;
    logic [DIM-1:0]   cur;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] tgt_idx;
    logic [DIM-1:0]   ca90_next;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    // CA90 datapath: each cell becomes the XOR of its two ring neighbours.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_ca90
        localparam int LEFT  = (gi + DIM - 1) % DIM;
        localparam int RIGHT = (gi + 1) % DIM;
        assign ca90_next[gi] = cur[LEFT] ^ cur[RIGHT];
    end

    // Handshake and status outputs derived directly from the state register,
    // so an asynchronous reset clears them without waiting for a clock.
    assign req_ready = (state == IDLE) && !seed_load;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_vec   = cur;

    // Sequencer: seed load / request accept in IDLE, stepping, response hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            cur     <= '0;
            cur_idx <= '0;
            tgt_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        // Seed wins over a same-cycle request.
                        base    <= seed;
                        cur     <= seed;
                        cur_idx <= '0;
                    end else if (req_valid) begin
                        tgt_idx <= req_idx;
                        if (req_idx < cur_idx) begin
                            // Cannot step backwards: restart from the base.
                            cur     <= base;
                            cur_idx <= '0;
                        end
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (cur_idx != tgt_idx) begin
                        cur     <= ca90_next;
                        cur_idx <= cur_idx + IDX_ONE;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // cur/cur_idx are kept so the next request can reuse them.
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ca90_seq.sv
// tb_ca90_seq: directed and randomized checks of ca90_seq (DIM=8, IDX_W=8)
// against a reference that applies the CA90 rule k times to the base vector.
module tb_ca90_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       req_valid = 1'b0;
    logic [7:0] req_idx = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_vec;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Reference state: the base vector and the generation the DUT should hold.
    logic [7:0] m_base = 8'h00;
    int         m_idx  = 0;

    ca90_seq #(.DIM(8), .IDX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_vec   (rsp_vec),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ca90_pow(input logic [7:0] b, input int k);
        logic [7:0] v;
        logic [7:0] n;
        v = b;
        for (int s = 0; s < k; s++) begin
            for (int i = 0; i < 8; i++) n[i] = v[(i + 7) % 8] ^ v[(i + 1) % 8];
            v = n;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load a seed while IDLE.
    task automatic load_seed(input logic [7:0] s);
        @(negedge clk);
        seed_load = 1'b1;
        seed = s;
        @(posedge clk);
        #1 seed_load = 1'b0;
        m_base = s;
        m_idx = 0;
    endtask

    // Issue a request, wait for acceptance and response, check latency and vector.
    task automatic issue(input int idx, input logic [7:0] exp_vec, input int exp_lat, input string tag);
        int w;
        int e;
        @(negedge clk);
        req_valid = 1'b1;
        req_idx = idx[7:0];
        w = 0;
        while (!req_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        e = 0;
        while (!rsp_valid && e < 400) begin
            @(posedge clk);
            #1;
            e++;
        end
        check({tag, "_lat"}, 64'(e), 64'(exp_lat));
        check({tag, "_vec"}, 64'(rsp_vec), 64'(exp_vec));
        $display("req idx=%0d vec=%02h latency=%0d", idx, rsp_vec, e);
        m_idx = idx;
    endtask

    // Consume the pending response.
    task automatic release_rsp(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check({tag, "_idle"}, {62'd0, busy, rsp_valid}, 64'd0);
    endtask

    // Request computed entirely from the reference model.
    task automatic model_req(input int idx, input string tag);
        int lat;
        lat = ((idx >= m_idx) ? (idx - m_idx) : idx) + 1;
        issue(idx, ca90_pow(m_base, idx), lat, tag);
    endtask

    initial begin
        logic [7:0] held;
        bit         seen;
        int         idx;

        // Reset state, checked without any clock edge in between.
        #1 rst = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_vec", 64'(rsp_vec), 64'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Seed 01, index 3: fresh computation, then reuse, then restart.
        load_seed(8'h01);
        issue(3, 8'hAA, 4, "idx3");
        release_rsp("idx3");
        issue(3, 8'hAA, 1, "reuse3");
        release_rsp("reuse3");
        issue(1, 8'h82, 2, "restart1");

        // Backpressure: response held, and a seed_load in RESP is ignored.
        seed_load = 1'b1;
        seed = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_state", {61'd0, rsp_valid, req_ready, busy}, 64'b101);
            check("bp_vec", 64'(rsp_vec), 64'h82);
        end
        seed_load = 1'b0;
        release_rsp("bp");
        issue(3, 8'hAA, 3, "after_bp");
        release_rsp("after_bp");

        // Seed and request together: seed wins, request accepted next cycle.
        @(negedge clk);
        seed_load = 1'b1;
        seed = 8'h01;
        req_valid = 1'b1;
        req_idx = 8'd2;
        @(posedge clk);
        #1;
        check("seed_prio_busy", 64'(busy), 64'd0);
        seed_load = 1'b0;
        m_base = 8'h01;
        m_idx = 0;
        issue(2, 8'h44, 3, "seed_prio");
        release_rsp("seed_prio");

        // Largest legal index.
        model_req(255, "max_idx");
        release_rsp("max_idx");

        // Reset in the middle of a long STEP phase.
        @(negedge clk);
        req_valid = 1'b1;
        req_idx = 8'd200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 220; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        check("midrst_no_rsp", 64'(seen), 64'd0);
        m_base = 8'h00;
        m_idx = 0;
        issue(5, 8'h00, 6, "zero_base");
        release_rsp("zero_base");

        // Randomized traffic against the reference model.
        load_seed(8'($urandom));
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 4) == 0) load_seed(8'($urandom));
            idx = $urandom_range(0, 24);
            model_req(idx, "rand");
            held = rsp_vec;
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                @(negedge clk);
                check("rand_hold", {55'd0, rsp_valid, rsp_vec}, {55'd0, 1'b1, held});
            end
            release_rsp("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
